butterfly_stage_sequencer: RTL

Control stage directly upstream of butterflyCore in the in-place radix-2 FFT datapath.
- Runs FFT_N stages; each stage issues 2^(FFT_N-1) butterfly beats (iact, ictrl, iMemAddr, twiddle address).
- Between stages, waits for the core's write-back to drain, then closes out the block-floating-point exponent.
- Consumes the core's oact/octrl/bw_ramwrite and drives the core's ibfp/clr_bfp for the next stage.

---
 rtl/fft_seq_pkg.sv | 29 ++
 rtl/butterfly_stage_sequencer_max.sv | 36 +++
 rtl/butterfly_stage_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fft_seq_pkg.sv
// Shared types and helpers for the FFT butterfly stage sequencer.
// Holds the sequencer state enum, ctrl bit indices and twiddle index math.
package fft_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    ISSUE,
    DRAIN,
    NEXT
  } seq_state_e;

  // Bit positions inside ictrl / octrl
  localparam int CTRL_FIRST = 0;
  localparam int CTRL_LAST  = 1;

  // Twiddle ROM index for butterfly k in stage stg of a 2^n point FFT:
  // keep the low stg bits of k, then scale into the half-length ROM.
  function automatic logic [31:0] twiddle_idx(
    input logic [31:0] k,
    input int unsigned stg,
    input int unsigned n
  );
    logic [31:0] mask;
    mask = (32'd1 << stg) - 32'd1;
    return (k & mask) << (n - 32'd1 - stg);
  endfunction

endpackage

// File: rtl/butterfly_stage_sequencer_max.sv
// Running maximum of write-back bit widths for block floating point.
// Ports: clk, rst (async low), clr_i, en_i, value_i -> max_o (registered).
module bfp_max_tracker #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] value_i,
  output logic [W-1:0] max_o
);

  logic [W-1:0] max_q;
  logic [W-1:0] max_d;

  always_comb begin
    max_d = max_q;
    if (clr_i) begin
      max_d = '0;
    end else if (en_i && (value_i > max_q)) begin
      max_d = value_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_q <= '0;
    end else begin
      max_q <= max_d;
    end
  end

  assign max_o = max_q;

endmodule

// File: rtl/butterfly_stage_sequencer.sv
// Stage sequencer feeding butterflyCore: issues per-stage beats, waits for
// write-back drain, tracks BFP exponent. Ports: start/bfp_init in, busy/done/
// bfp_final/stage status out, iact/ictrl/iMemAddr/twiddle_addr/ibfp/clr_bfp
// to the core, oact/octrl/bw_ramwrite from the core.
module butterfly_stage_sequencer
  import fft_seq_pkg::*;
#(
  parameter int FFT_N     = 10,
  parameter int FFT_BFPDW = 5,
  parameter int FFT_STGW  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [FFT_BFPDW-1:0] bfp_init,
  output logic                 busy,
  output logic                 done,
  output logic [FFT_BFPDW-1:0] bfp_final,
  output logic [FFT_STGW-1:0]  stage,
  output logic                 iact,
  output logic [1:0]           ictrl,
  output logic [FFT_N-2:0]     iMemAddr,
  output logic [FFT_N-2:0]     twiddle_addr,
  output logic [FFT_BFPDW-1:0] ibfp,
  output logic                 clr_bfp,
  input  logic                 oact,
  input  logic [1:0]           octrl,
  input  logic [FFT_BFPDW-1:0] bw_ramwrite
);

  localparam int KW = FFT_N - 1;
  localparam logic [KW-1:0] KMAX = {KW{1'b1}};
  localparam logic [FFT_STGW-1:0] LAST_STG = FFT_STGW'(FFT_N - 1);

  seq_state_e state_q;

  logic                 busy_q;
  logic                 done_q;
  logic [FFT_BFPDW-1:0] bfp_final_q;
  logic [FFT_STGW-1:0]  stage_q;
  logic                 iact_q;
  logic [1:0]           ictrl_q;
  logic [KW-1:0]        k_q;
  logic [KW-1:0]        tw_q;
  logic [FFT_BFPDW-1:0] ibfp_q;
  logic                 clr_q;

  logic [KW-1:0]        k_d;
  logic [KW-1:0]        tw_d;
  logic [1:0]           ctrl_d;
  logic                 wb_last;
  logic                 trk_en;
  logic                 trk_clr;
  logic [FFT_BFPDW-1:0] trk_max;
  logic                 unused_octrl;

  assign unused_octrl = octrl[CTRL_FIRST];

  // Write-backs only count while a stage is in flight; anything the core
  // emits outside ISSUE/DRAIN (e.g. after a reset) is discarded.
  assign trk_en  = oact && ((state_q == ISSUE) || (state_q == DRAIN));
  assign trk_clr = (state_q == CLR);
  assign wb_last = oact && octrl[CTRL_LAST];

  // Next beat's address, twiddle and ctrl, precomputed so outputs stay
  // registered.
  always_comb begin
    k_d    = k_q + 1'b1;
    tw_d   = KW'(twiddle_idx(32'(k_d), 32'(stage_q), 32'(FFT_N)));
    ctrl_d = '0;
    ctrl_d[CTRL_LAST] = (k_d == KMAX);
  end

  bfp_max_tracker #(
    .W (FFT_BFPDW)
  ) u_max (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (trk_clr),
    .en_i    (trk_en),
    .value_i (bw_ramwrite),
    .max_o   (trk_max)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bfp_final_q <= '0;
      stage_q     <= '0;
      iact_q      <= 1'b0;
      ictrl_q     <= '0;
      k_q         <= '0;
      tw_q        <= '0;
      ibfp_q      <= '0;
      clr_q       <= 1'b0;
    end else begin
      clr_q  <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= CLR;
            ibfp_q  <= bfp_init;
            stage_q <= '0;
            busy_q  <= 1'b1;
            clr_q   <= 1'b1;
          end
        end
        CLR: begin
          state_q <= ISSUE;
          iact_q  <= 1'b1;
          k_q     <= '0;
          tw_q    <= '0;
          ictrl_q <= 2'(1 << CTRL_FIRST);
        end
        ISSUE: begin
          if (k_q == KMAX) begin
            state_q <= DRAIN;
            iact_q  <= 1'b0;
            ictrl_q <= '0;
          end else begin
            k_q     <= k_d;
            tw_q    <= tw_d;
            ictrl_q <= ctrl_d;
          end
        end
        DRAIN: begin
          // The in-place RAM must be fully written before the next stage
          // reads it, so only the core's last-write marker releases us.
          if (wb_last) begin
            state_q <= NEXT;
          end
        end
        NEXT: begin
          if (stage_q == LAST_STG) begin
            bfp_final_q <= trk_max;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else begin
            ibfp_q  <= trk_max;
            stage_q <= stage_q + 1'b1;
            clr_q   <= 1'b1;
            state_q <= CLR;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign bfp_final    = bfp_final_q;
  assign stage        = stage_q;
  assign iact         = iact_q;
  assign ictrl        = ictrl_q;
  assign iMemAddr     = k_q;
  assign twiddle_addr = tw_q;
  assign ibfp         = ibfp_q;
  assign clr_bfp      = clr_q;

endmodule
